// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 start-light sequencer.
// Contents: sequencer state type, LFSR width/seed/taps, default light count.
package f1_pkg;

    typedef enum logic [1:0] {IDLE, LIGHT, HOLD, FIRE} state_t;

    localparam int         LFSR_W      = 7;
    localparam logic [6:0] LFSR_SEED   = 7'h01;
    // x^7 + x^6 + 1: feedback is bit6 ^ bit5, maximal length 127
    localparam int         LFSR_TAP_HI = 6;
    localparam int         LFSR_TAP_LO = 5;

    localparam int         LIGHTS_DEF  = 8;

endpackage

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running 7-bit Fibonacci LFSR supplying the random hold length.
// Ports: clk  - system clock
//        rst_n - asynchronous active-low reset, reloads the seed
//        out  - current LFSR state, never zero
module f1_lfsr
    import f1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;

    assign out = lfsr_q;

endmodule

// File: rtl/f1_start_seq.sv
// f1_start_seq: strobe sequencer stepping the F1 start-lights FSM S0->S8->S0.
// Ports: clk        - system clock
//        rst_n      - asynchronous active-low reset
//        trigger    - start request, acted on only while idle
//        n          - tick period minus one, captured on accepted trigger
//        en         - one-cycle strobe to the lights FSM
//        go         - one-cycle pulse with the final lights-out strobe
//        busy       - high while a sequence is running
//        hold_ticks - hold length chosen for the current run
// Build option: define F1_FIXED_DELAY_EN to replace the LFSR hold with the
// constant FIXED_DELAY (must be nonzero).
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LIGHTS = LIGHTS_DEF
`ifdef F1_FIXED_DELAY_EN
    ,
    parameter logic [6:0] FIXED_DELAY = 7'd20
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic [WIDTH-1:0] n,
    output logic             en,
    output logic             go,
    output logic             busy,
    output logic [6:0]       hold_ticks
);

    localparam int CW = $clog2(LIGHTS) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d, presc_q, presc_d;
    logic [CW-1:0]    light_q, light_d;
    logic [6:0]       hold_q, hold_d, ht_q, ht_d, hold_load;
    logic             en_q, en_d, go_q, go_d, busy_q, busy_d, tick;

`ifdef F1_FIXED_DELAY_EN
    assign hold_load = FIXED_DELAY;
`else
    f1_lfsr u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .out  (hold_load)
    );
`endif

    assign tick = presc_q == '0;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        presc_d = presc_q;
        light_d = light_q;
        hold_d  = hold_q;
        ht_d    = ht_q;
        en_d    = 1'b0;
        go_d    = 1'b0;
        // busy trails the state by one cycle so it stays high through FIRE's output cycle
        busy_d  = state_q != IDLE;
        case (state_q)
            IDLE: if (trigger) begin
                n_d     = n;
                presc_d = n;
                light_d = '0;
                state_d = LIGHT;
            end
            LIGHT: begin
                presc_d = tick ? n_q : presc_q - 1'b1;
                if (tick) begin
                    en_d    = 1'b1;
                    light_d = light_q + 1'b1;
                    if (light_q == CW'(LIGHTS - 1)) begin
                        hold_d  = hold_load;
                        ht_d    = hold_load;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                presc_d = tick ? n_q : presc_q - 1'b1;
                if (tick) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == 7'd1) state_d = FIRE;
                end
            end
            FIRE: begin
                en_d    = 1'b1;
                go_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            presc_q <= '0;
            light_q <= '0;
            hold_q  <= '0;
            ht_q    <= '0;
            en_q    <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            presc_q <= presc_d;
            light_q <= light_d;
            hold_q  <= hold_d;
            ht_q    <= ht_d;
            en_q    <= en_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end

    assign en         = en_q;
    assign go         = go_q;
    assign busy       = busy_q;
    assign hold_ticks = ht_q;

endmodule
